// File: rtl/keypad_uart_tx_pkg.sv
// Shared constants for the keypad UART transmitter: FSM encoding, frame shape and key codes.
package keypad_uart_tx_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } state_e;

  localparam int unsigned DataBits  = 8;
  localparam logic        IdleLevel = 1'b1;

  // Key codes shared with the keypad controller
  localparam logic [7:0] KeyW = 8'h77;
  localparam logic [7:0] KeyA = 8'h61;
  localparam logic [7:0] KeyS = 8'h73;
  localparam logic [7:0] KeyD = 8'h64;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: one-cycle tick at count CLKS_PER_BIT-1, wraps, synchronous clear.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q;

  assign tick = (cnt_q == CntLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/keypad_uart_tx.sv
// Serializes one accepted keypad byte as UART 8N1/8N2, LSB first, with a one-cycle accept pulse.
module keypad_uart_tx
  import keypad_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tx_key_send,
  input  logic [7:0] i_key,
  output logic       o_tx_keypad_proc,
  output logic       o_uart_tx,
  output logic       o_busy
);

  localparam logic [2:0] DataLast = 3'(DataBits - 1);
  localparam logic [2:0] StopLast = 3'(STOP_BITS - 1);

  state_e     state_q;
  logic [7:0] shift_q;
  logic [2:0] bit_idx_q;
  logic       tx_q;
  logic       proc_q;
  logic       busy_q;
  logic       tick;

  // Held clear in idle so every bit period starts from zero on state entry
  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q == StIdle),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= IdleLevel;
      proc_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      proc_q <= 1'b0;
      case (state_q)
        StIdle: begin
          tx_q   <= IdleLevel;
          busy_q <= 1'b0;
          if (i_tx_key_send) begin
            shift_q <= i_key;
            state_q <= StStart;
            tx_q    <= ~IdleLevel;
            proc_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StStart: begin
          if (tick) begin
            state_q   <= StData;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
          end
        end
        StData: begin
          if (tick) begin
            if (bit_idx_q == DataLast) begin
              state_q   <= StStop;
              bit_idx_q <= '0;
              tx_q      <= IdleLevel;
            end else begin
              // Line is registered, so drive the bit that becomes LSB after this shift
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        StStop: begin
          if (tick) begin
            if (bit_idx_q == StopLast) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_uart_tx        = tx_q;
  assign o_tx_keypad_proc = proc_q;
  assign o_busy           = busy_q;

endmodule
